// File: rtl/contour_point_streamer_pkg.sv
// Shared image geometry, FSM encoding and output beat layout for the contour point streamer.
package img_pkg;

    localparam int IMG_W   = 640;
    localparam int IMG_H   = 480;
    localparam int ADDR_W  = 19;
    localparam int LABEL_W = 3;

    localparam logic [LABEL_W-1:0] LABEL_BG = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_MARK  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] bin;
        logic       eob;
    } point_t;

    localparam int POINT_W = $bits(point_t);

endpackage

// File: rtl/contour_point_streamer_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module point_fifo #(
    parameter int W     = 23,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/contour_point_streamer.sv
// Scans the labelled edge BRAM once per bin and streams matching (x,y,bin) points plus one end-of-bin beat per bin.
module contour_point_streamer
    import img_pkg::*;
#(
    parameter int FRAME_W    = IMG_W,
    parameter int FRAME_H    = IMG_H,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk_25mhz,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         num_bins,
    output logic [ADDR_W-1:0]  edge_bram_addrb,
    input  logic [LABEL_W-1:0] edge_bram_doutb,
    output logic               point_valid,
    input  logic               point_ready,
    output logic [9:0]         point_x,
    output logic [8:0]         point_y,
    output logic [2:0]         point_bin,
    output logic               point_eob,
    output logic [11:0]        point_count,
    output logic               busy,
    output logic               done,
    output logic [2:0]         fsm_state
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);
    localparam logic [9:0]        X_LAST    = 10'(FRAME_W - 1);
    localparam logic [8:0]        Y_LAST    = 9'(FRAME_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [9:0]        x_q;
    logic [8:0]        y_q;
    logic [2:0]        bin_q, nbins_q;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [11:0]       count_q, count_d;
    logic [RD_LAT-1:0] vld_q;
    logic [9:0]        xd_q [RD_LAT];
    logic [8:0]        yd_q [RD_LAT];

    logic              issue, retire, pt_push, mark_push, push, pop;
    logic              start_ok, credit_ok;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    point_t            push_beat, head;

    // A read may only be issued if the FIFO is guaranteed room for its result, so no beat is ever dropped.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign retire    = vld_q[RD_LAT-1];

    always_ff @(posedge clk_25mhz) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_ok) state_d = (num_bins == 3'd0) ? ST_DONE : ST_SCAN;
            ST_SCAN:          if (issue && addr_q == LAST_ADDR) state_d = ST_DRAIN;
            ST_DRAIN:         if (inflight_q == '0) state_d = ST_MARK;
            ST_MARK:          if (!fifo_full) state_d = (bin_q == nbins_q) ? ST_DONE : ST_SCAN;
            default:          state_d = ST_IDLE;
        endcase
    end

    // DONE only reports completion once the last end-of-bin beat has left the FIFO.
    always_comb begin
        issue     = (state_q == ST_SCAN) && credit_ok;
        mark_push = (state_q == ST_MARK) && !fifo_full;
        done      = (state_q == ST_DONE) && fifo_empty;
        busy      = (state_q != ST_IDLE) && !done;
        start_ok  = start && !busy;
        fsm_state = state_q;
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bin_q   <= '0;
            nbins_q <= '0;
        end else if (start_ok) begin
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bin_q   <= 3'd1;
            nbins_q <= num_bins;
        end else if (issue) begin
            addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            x_q    <= (x_q == X_LAST) ? '0 : x_q + 1'b1;
            if (x_q == X_LAST) y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else if (mark_push && bin_q != nbins_q) begin
            bin_q <= bin_q + 1'b1;
        end
    end

    assign edge_bram_addrb = addr_q;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        xd_q[0] <= x_q;
        yd_q[0] <= y_q;
        for (int i = 1; i < RD_LAT; i++) begin
            xd_q[i] <= xd_q[i-1];
            yd_q[i] <= yd_q[i-1];
        end
    end

    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(retire);
    assign pt_push    = retire && edge_bram_doutb != LABEL_BG && edge_bram_doutb == bin_q;
    assign push       = pt_push || mark_push;

    always_comb begin
        push_beat     = '0;
        push_beat.bin = bin_q;
        if (mark_push) begin
            push_beat.eob = 1'b1;
        end else begin
            push_beat.x = xd_q[RD_LAT-1];
            push_beat.y = yd_q[RD_LAT-1];
        end
    end

    point_fifo #(.W(POINT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_25mhz),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_beat),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // valid/ready: a beat transfers on a rising edge where point_valid && point_ready; until then it is held stable.
    assign point_valid = !fifo_empty;
    assign pop         = point_valid && point_ready;
    assign point_x     = point_valid ? head.x   : '0;
    assign point_y     = point_valid ? head.y   : '0;
    assign point_bin   = point_valid ? head.bin : '0;
    assign point_eob   = point_valid && head.eob;

    always_comb begin
        count_d = count_q;
        if (pop) begin
            if (head.eob)                count_d = '0;
            else if (count_q != 12'hFFF) count_d = count_q + 12'd1;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign point_count = count_q;

endmodule
